pipelined_adder: RTL and testbench

//   Parametrised N-bit add/subtract unit built as a carry-chunked pipeline of ripple adders.

---
 rtl/alu_arith_pkg.sv | 15 +
 rtl/fulladder.sv | 13 +
 rtl/ripple_chunk.sv | 33 +++
 rtl/pipelined_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_adder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arith_pkg.sv
// Shared arithmetic definitions for the ALU add/subtract datapath.
// Operation encoding maps directly onto the sub_i pin of pipelined_adder.
package alu_arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, the building block of the ripple chunks.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/ripple_chunk.sv
// CHUNK-bit combinational ripple-carry adder built from a chain of full adders.
// The slice result is effectively CHUNK+1 bits wide: {c_o, s_o}.
module ripple_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    // Carry is kept per bit-block so the chain is never a self-dependent vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_lsb
            assign w_ci = c_i;
        end else begin : g_link
            assign w_ci = g_bit[i-1].w_co;
        end
        fulladder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (w_ci),
            .s_o (s_o[i]),
            .c_o (w_co)
        );
    end

    assign c_o = g_bit[CHUNK-1].w_co;

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract unit pipelined as STAGES carry-chunked ripple adders,
// with valid/ready flow control, backpressure, flush and signed overflow.
module pipelined_adder
    import alu_arith_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sub_i,
    input  logic             carry_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_width_check
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    op_e w_op;
    assign w_op = sub_i ? OP_SUB : OP_ADD;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic              r_ovf;

    logic [STAGES-1:0] w_rdy;
    logic              w_vin  [STAGES];
    logic [WIDTH-1:0]  w_a    [STAGES];
    logic [WIDTH-1:0]  w_b    [STAGES];
    logic [WIDTH-1:0]  w_sum  [STAGES];
    logic              w_cin  [STAGES];
    logic              w_cout [STAGES];
    logic              w_ovf;

    // Ready propagates from the output back; an empty stage is always ready.
    always_comb begin
        w_rdy       = '0;
        w_rdy[LAST] = out_ready_i || !r_valid[LAST];
        for (int unsigned i = 1; i < STAGES; i++) begin
            w_rdy[LAST-i] = w_rdy[LAST-i+1] || !r_valid[LAST-i];
        end
    end

    assign in_ready_o = w_rdy[0] && !flush_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_slice;
        logic [WIDTH-1:0] w_part;
        logic [WIDTH-1:0] w_merge;

        if (k == 0) begin : g_entry
            assign w_vin[k]  = in_valid_i;
            assign w_a[k]    = a_i;
            assign w_b[k]    = (w_op == OP_SUB) ? ~b_i : b_i;
            assign w_cin[k]  = (w_op == OP_SUB) ? 1'b1 : carry_i;
            assign w_part    = '0;
        end else begin : g_link
            assign w_vin[k]  = r_valid[k-1];
            assign w_a[k]    = r_a[k-1];
            assign w_b[k]    = r_b[k-1];
            assign w_cin[k]  = r_carry[k-1];
            assign w_part    = r_sum[k-1];
        end

        ripple_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i (w_a[k][k*CHUNK +: CHUNK]),
            .b_i (w_b[k][k*CHUNK +: CHUNK]),
            .c_i (w_cin[k]),
            .s_o (w_slice),
            .c_o (w_cout[k])
        );

        always_comb begin
            w_merge                    = w_part;
            w_merge[k*CHUNK +: CHUNK]  = w_slice;
        end

        assign w_sum[k] = w_merge;
    end

    // The last stage completes the MSB slice, so overflow is resolved there.
    assign w_ovf = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1]) &&
                   (w_sum[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= '0;
            r_carry <= '0;
            r_ovf   <= 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_a[i]   <= '0;
                r_b[i]   <= '0;
                r_sum[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (flush_i) begin
                    r_valid[i] <= 1'b0;
                end else if (w_rdy[i]) begin
                    r_valid[i] <= w_vin[i];
                end
                if (!flush_i && w_rdy[i] && w_vin[i]) begin
                    r_a[i]     <= w_a[i];
                    r_b[i]     <= w_b[i];
                    r_sum[i]   <= w_sum[i];
                    r_carry[i] <= w_cout[i];
                end
            end
            if (!flush_i && w_rdy[LAST] && w_vin[LAST]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign out_valid_o = r_valid[LAST];
    assign sum_o       = r_sum[LAST];
    assign carry_o     = r_carry[LAST];
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed 32-bit/4-stage vectors plus
// randomised add/sub on 8/1, 32/2 and 64/8 configurations against a reference model.
module tb_pipelined_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic         clk       = 1'b0;
    logic         rst_ni    = 1'b1;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         sub       = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready_o;
    logic         out_valid_o;
    logic [W-1:0] sum_o;
    logic         carry_o;
    logic         overflow_o;

    logic        rv   = 1'b0;
    logic        rsub = 1'b0;
    logic        rcin = 1'b0;
    logic [63:0] ra   = '0;
    logic [63:0] rb   = '0;
    logic        r8_ir, r8_ov, r8_c, r8_o;
    logic [7:0]  r8_s;
    logic        r32_ir, r32_ov, r32_c, r32_o;
    logic [31:0] r32_s;
    logic        r64_ir, r64_ov, r64_c, r64_o;
    logic [63:0] r64_s;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready_o), .sub_i(sub), .carry_i(cin), .a_i(a), .b_i(b),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready), .sum_o(sum_o),
        .carry_o(carry_o), .overflow_o(overflow_o)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(1'b0), .in_valid_i(rv),
        .in_ready_o(r8_ir), .sub_i(rsub), .carry_i(rcin), .a_i(ra[7:0]), .b_i(rb[7:0]),
        .out_valid_o(r8_ov), .out_ready_i(1'b1), .sum_o(r8_s), .carry_o(r8_c), .overflow_o(r8_o)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(2)) u_w32 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(1'b0), .in_valid_i(rv),
        .in_ready_o(r32_ir), .sub_i(rsub), .carry_i(rcin), .a_i(ra[31:0]), .b_i(rb[31:0]),
        .out_valid_o(r32_ov), .out_ready_i(1'b1), .sum_o(r32_s), .carry_o(r32_c), .overflow_o(r32_o)
    );

    pipelined_adder #(.WIDTH(64), .STAGES(8)) u_w64 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(1'b0), .in_valid_i(rv),
        .in_ready_o(r64_ir), .sub_i(rsub), .carry_i(rcin), .a_i(ra), .b_i(rb),
        .out_valid_o(r64_ov), .out_ready_i(1'b1), .sum_o(r64_s), .carry_o(r64_c), .overflow_o(r64_o)
    );

    // Directed vectors: {sub, carry_in, a, b, expected sum, expected carry, expected overflow}
    typedef struct packed {
        logic        sub;
        logic        cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    vec_t V [12] = '{
        '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
        '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1},
        '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0},
        '{1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1},
        '{1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 32'h2345_678A, 1'b0, 1'b0},
        '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
        '{1'b0, 1'b1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001, 1'b0, 1'b0},
        '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0007, 32'hFFFF_FFFC, 1'b0, 1'b0},
        '{1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1},
        '{1'b1, 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1},
        '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0},
        '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0}
    };

    typedef struct {
        logic [65:0] res;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q [$];
    exp_t        e_mon;
    logic [65:0] q8  [$];
    logic [65:0] q32 [$];
    logic [65:0] q64 [$];

    function automatic void check(string name, logic [65:0] got, logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic logic [65:0] vexp(int i);
        return {V[i].o, V[i].c, 32'h0, V[i].s};
    endfunction

    function automatic logic [65:0] model(int unsigned w, logic [63:0] x, logic [63:0] y,
                                          logic sb, logic ci);
        logic [63:0] m, am, bm, s;
        logic [64:0] full;
        logic        c, o;
        m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am   = x & m;
        bm   = (sb ? ~y : y) & m;
        full = {1'b0, am} + {1'b0, bm} + {64'd0, (sb ? 1'b1 : ci)};
        s    = full[63:0] & m;
        c    = full[w];
        o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {o, c, s};
    endfunction

    // Main scoreboard monitor: a result is consumed only when out_valid && out_ready && !flush.
    always @(negedge clk) begin
        if (rst_ni && out_valid_o && out_ready && !flush) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got sum=%h, expected no result", sum_o);
            end else begin
                e_mon = q.pop_front();
                check("result", {overflow_o, carry_o, 32'h0, sum_o}, e_mon.res);
                if (e_mon.lat) check("latency", 66'(cyc - e_mon.cyc), 66'(S));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_ni && r8_ov) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL w8s1_unexpected: got sum=%h, expected no result", r8_s);
            end else check("w8s1", {r8_o, r8_c, 56'h0, r8_s}, q8.pop_front());
        end
        if (rst_ni && r32_ov) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL w32s2_unexpected: got sum=%h, expected no result", r32_s);
            end else check("w32s2", {r32_o, r32_c, 32'h0, r32_s}, q32.pop_front());
        end
        if (rst_ni && r64_ov) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL w64s8_unexpected: got sum=%h, expected no result", r64_s);
            end else check("w64s8", {r64_o, r64_c, r64_s}, q64.pop_front());
        end
    end

    task automatic drive(int i);
        sub      = V[i].sub;
        cin      = V[i].cin;
        a        = V[i].a;
        b        = V[i].b;
        in_valid = 1'b1;
    endtask

    task automatic send(int i, bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        drive(i);
        for (int t = 0; t < 40 && !done; t++) begin
            @(negedge clk);
            if (in_ready_o) begin
                e.res = vexp(i);
                e.cyc = cyc;
                e.lat = lat;
                q.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: vector %0d not accepted, expected acceptance within 40 cycles", i);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drained", 66'(q.size()), 66'd0);
        q.delete();
        repeat (S + 2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_flush(int n);
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) send(i, 1'b0);
        drive(n);
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 66'(in_ready_o), 66'd0);
        if (n >= int'(S)) check("flush_full_valid", 66'(out_valid_o), 66'd1);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check("flush_out_valid", 66'(out_valid_o), 66'd0);
        out_ready = 1'b1;
        send(7, 1'b1);
        in_valid = 1'b0;
        drain();
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #11;
        check("reset_outputs", {out_valid_o, overflow_o, carry_o, 31'h0, sum_o}, 66'd0);
        check("reset_in_ready", 66'(in_ready_o), 66'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // single beats, then back-to-back pairs and an 8-beat burst at full rate
        send(0, 1'b1);
        in_valid = 1'b0;
        drain();
        send(1, 1'b1);
        send(2, 1'b1);
        in_valid = 1'b0;
        drain();
        for (int i = 3; i <= 10; i++) send(i, 1'b1);
        in_valid = 1'b0;
        drain();
        send(11, 1'b1);
        in_valid = 1'b0;
        drain();

        // backpressure: six stalled cycles fill exactly S stages, head held stable
        begin
            int idx;
            int accepted;
            exp_t e;
            idx = 0;
            accepted = 0;
            out_ready = 1'b0;
            for (int c = 0; c < 6; c++) begin
                drive(idx);
                @(negedge clk);
                if (out_valid_o) check("stall_hold", {overflow_o, carry_o, 32'h0, sum_o}, q[0].res);
                if (in_ready_o) begin
                    e.res = vexp(idx);
                    e.cyc = cyc;
                    e.lat = 1'b0;
                    q.push_back(e);
                    idx++;
                    accepted++;
                end
                @(posedge clk); #1;
            end
            check("stall_accepts", 66'(accepted), 66'(S));
            check("stall_in_ready", 66'(in_ready_o), 66'd0);
            out_ready = 1'b1;
            for (int i = idx; i < 12; i++) send(i, 1'b0);
            in_valid = 1'b0;
            drain();
        end

        do_flush(4);
        do_flush(2);

        // asynchronous reset between edges while results are streaming
        out_ready = 1'b1;
        for (int i = 6; i <= 11; i++) send(i, 1'b1);
        in_valid = 1'b0;
        check("prereset_valid", 66'(out_valid_o), 66'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", {out_valid_o, overflow_o, carry_o, 31'h0, sum_o}, 66'd0);
        q.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        drain();
        send(3, 1'b1);
        in_valid = 1'b0;
        drain();

        // randomised add/sub across the other configurations
        for (int n = 0; n < 80; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            if (n % 10 == 0) rb = ~ra;
            rsub = 1'($urandom_range(0, 1));
            rcin = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rv && r8_ir)  q8.push_back(model(8, ra, rb, rsub, rcin));
            if (rv && r32_ir) q32.push_back(model(32, ra, rb, rsub, rcin));
            if (rv && r64_ir) q64.push_back(model(64, ra, rb, rsub, rcin));
            @(posedge clk); #1;
        end
        rv = 1'b0;
        for (int t = 0; t < 30 && (q8.size() + q32.size() + q64.size()) != 0; t++) begin
            @(posedge clk); #1;
        end
        check("random_drained", 66'(q8.size() + q32.size() + q64.size()), 66'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
